// File: rtl/firc_out_serializer_if.sv
// Filter-result capture and 32-bit I/Q output stream bundle for firc_out_serializer.
// slave = serializer side, master = filter/downstream environment side.
interface firc_out_serializer_if;
  logic        PushOut;
  logic [31:0] FI;
  logic [31:0] FQ;
  logic        DOutValid;
  logic        DOutReady;
  logic [31:0] DOut;
  logic        DOutIsQ;

  modport master (output PushOut, FI, FQ, DOutReady, input DOutValid, DOut, DOutIsQ);
  modport slave  (input PushOut, FI, FQ, DOutReady, output DOutValid, DOut, DOutIsQ);
endinterface

// File: rtl/firc_out_serializer.sv
// Captures every {FI,FQ} filter result into a FIFO and serializes each pair as I then Q words.
// Optional delivered-pair counter enabled by defining FIRC_OUT_PAIRCNT_EN.
module firc_out_serializer #(
  parameter int DEPTH    = 8,
  parameter int AF_LEVEL = 6
) (
  input  logic                       clk,
  input  logic                       Reset,
  firc_out_serializer_if.slave       bus,
  output logic [$clog2(DEPTH+1)-1:0] Level,
  output logic                       AlmostFull,
  output logic                       Overflow,
  input  logic                       ClrOvf,
  output logic [15:0]                PairCnt
);
  localparam int DATA_W = 32;
  localparam int PW     = $clog2(DEPTH);
  localparam int LW     = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, SEND_I, SEND_Q} state_t;
  state_t state, state_nxt;

  logic [2*DATA_W-1:0] mem [DEPTH];
  logic [2*DATA_W-1:0] stage_p0;
  logic [PW-1:0]       wr_ptr, rd_ptr;
  logic [LW-1:0]       level_nxt;
  logic                accept, pop, load_q, go_idle, full, push_ok, drop;

  assign accept    = bus.DOutValid && bus.DOutReady;
  assign full      = (Level == LW'(DEPTH));
  // A pop on the same edge frees a slot, so a full FIFO can still take the push.
  assign push_ok   = bus.PushOut && (!full || pop);
  assign drop      = bus.PushOut && full && !pop;
  assign level_nxt = Level + LW'(push_ok) - LW'(pop);

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    load_q    = 1'b0;
    go_idle   = 1'b0;
    case (state)
      IDLE: begin
        if (Level != '0) begin
          pop       = 1'b1;
          state_nxt = SEND_I;
        end
      end
      SEND_I: begin
        if (accept) begin
          load_q    = 1'b1;
          state_nxt = SEND_Q;
        end
      end
      SEND_Q: begin
        if (accept) begin
          if (Level != '0) begin
            pop       = 1'b1;
            state_nxt = SEND_I;
          end else begin
            go_idle   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p0: FIFO storage and the staging register holding the popped pair
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {bus.FI, bus.FQ};
    if (pop)     stage_p0    <= mem[rd_ptr];
  end

  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      Level      <= '0;
      AlmostFull <= 1'b0;
      Overflow   <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop)     rd_ptr <= rd_ptr + PW'(1);
      Level      <= level_nxt;
      AlmostFull <= (level_nxt >= LW'(AF_LEVEL));
      if (drop)        Overflow <= 1'b1;
      else if (ClrOvf) Overflow <= 1'b0;
    end
  end

  // Stage p1: registered output word
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      bus.DOutValid <= 1'b0;
      bus.DOut      <= '0;
      bus.DOutIsQ   <= 1'b0;
    end else if (pop) begin
      bus.DOut      <= mem[rd_ptr][2*DATA_W-1:DATA_W];
      bus.DOutIsQ   <= 1'b0;
      bus.DOutValid <= 1'b1;
    end else if (load_q) begin
      bus.DOut      <= stage_p0[DATA_W-1:0];
      bus.DOutIsQ   <= 1'b1;
    end else if (go_idle) begin
      bus.DOutValid <= 1'b0;
    end
  end

`ifdef FIRC_OUT_PAIRCNT_EN
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset)                        PairCnt <= '0;
    else if (accept && state == SEND_Q) PairCnt <= PairCnt + 16'd1;
  end
`else
  assign PairCnt = 16'h0000;
`endif

endmodule

// File: doc/firc_out_serializer.md
# firc_out_serializer

Output-side receiver for the complex FIR filter. Captures every `PushOut`/`FI`/`FQ` result pair the filter emits; the filter has no output backpressure, so nothing may be missed. Buffers the pairs in a small FIFO and serializes each pair onto a single 32-bit valid/ready stream as I word then Q word. Sits between the filter output and the downstream packetizer/host interface.

## Interface
Parameters:
- `DEPTH`, default 8: FIFO depth in {FI,FQ} pairs; power of two, minimum 4.
- `AF_LEVEL`, default 6: `AlmostFull` threshold, in pairs; must be less than `DEPTH`.

Ports:
- `clk`  in  1  clock; all logic is rising-edge.
- `Reset`  in  1  asynchronous, active-high reset.
- `PushOut`  in  1  filter result valid, single-cycle strobe.
- `FI`  in  32  filter I result; sampled when `PushOut`=1.
- `FQ`  in  32  filter Q result; sampled when `PushOut`=1.
- `DOutValid`  out  1  `DOut` holds a valid word.
- `DOutReady`  in  1  downstream accepts the word on a rising edge where `DOutValid`=1.
- `DOut`  out  32  serialized word.
- `DOutIsQ`  out  1  0 = current word is I; 1 = current word is Q.
- `Level`  out  $clog2(DEPTH+1)  number of pairs held in the FIFO. Excludes the pair in the output register.
- `AlmostFull`  out  1  1 when `Level` ≥ `AF_LEVEL`.
- `Overflow`  out  1  sticky drop flag.
- `ClrOvf`  in  1  synchronous clear of `Overflow`.
- `PairCnt`  out  16  count of delivered pairs; see Configuration.

## Operation
- FIFO:
  - Circular buffer of `DEPTH` 64-bit entries {FI,FQ}.
  - Write and read pointers wrap modulo `DEPTH`.
  - A separate occupancy counter gives `Level`.
- Write rule:
  - `PushOut`=1 and FIFO not full: store the pair.
  - `PushOut`=1 and FIFO full, with a pop on the same edge: store the pair.
  - `PushOut`=1 and FIFO full, with no pop on the same edge: drop the new pair and set `Overflow`=1. FIFO contents are unchanged.
- `Overflow` behaviour:
  - Cleared by `Reset` or by `ClrOvf`=1.
  - If `ClrOvf` and a drop occur on the same edge, the set wins.
- Serializer FSM, three states:
  - IDLE: `DOutValid`=0. If `Level`>0, pop a pair, load `DOut`<=FI, `DOutIsQ`<=0, `DOutValid`<=1, go to SEND_I.
  - SEND_I: hold `DOut` stable until accepted. On accept, load `DOut`<=held FQ, `DOutIsQ`<=1, go to SEND_Q.
  - SEND_Q: hold `DOut` stable until accepted. On accept:
    - if `Level`>0, pop the next pair, load its FI, `DOutIsQ`<=0, go to SEND_I (back-to-back, no bubble);
    - otherwise `DOutValid`<=0, go to IDLE.
- A popped pair is held in a 64-bit staging register; the Q half is taken from there.
- Simultaneous push and pop on one edge:
  - `Level` is unchanged;
  - the push uses the pre-edge full status, with the pop credited.
- Push into an empty FIFO while in IDLE: the pair is written first; the FSM pops it on the next edge. There is no bypass path.

## Timing
- Reset values:
  - `DOutValid`=0, `DOut`=0, `DOutIsQ`=0;
  - `Level`=0, `AlmostFull`=0, `Overflow`=0, `PairCnt`=0;
  - FSM in IDLE;
  - pointers at 0.
- Reset asserted mid-transfer: all in-flight and buffered pairs are discarded; outputs return to their reset values immediately.
- Latency:
  - `PushOut` sampled at edge N writes the FIFO at N.
  - Edge N+1 pops it, and `DOutValid`/I word are visible after N+1.
  - So the I word appears 1 cycle after the write edge; the Q word is earliest 1 cycle after I is accepted.
- Throughput: 1 pair per 2 cycles with `DOutReady` held at 1.
- `DOut`, `DOutIsQ` and `DOutValid` are registered outputs. They are stable while `DOutValid`=1 and `DOutReady`=0.
- `Level` and `AlmostFull` are registered and update on the edge of the push/pop.

## Configuration
- `FIRC_OUT_PAIRCNT_EN` defined:
  - `PairCnt` increments by 1 on each accepted Q word and wraps at 16 bits.
  - It is cleared only by `Reset`.
- `FIRC_OUT_PAIRCNT_EN` undefined:
  - the counter logic is not compiled;
  - `PairCnt` is tied to 16'h0000.

## Test plan
- Single pair, `DOutReady`=1:
  - Stimulus: `PushOut` with FI=32'h0000_1234, FQ=32'hFFFF_EDCC.
  - Response: I word 32'h0000_1234 with `DOutIsQ`=0 one cycle after the write edge. The next cycle carries Q word 32'hFFFF_EDCC with `DOutIsQ`=1. Then `DOutValid`=0 and `Level`=0.
- Backpressure:
  - Stimulus: 3 pairs pushed while `DOutReady`=0 for 10 cycles.
  - Response: `DOut` holds the first I word stable and `Level`=2. After `DOutReady`=1, the 6 words emerge in order I0,Q0,I1,Q1,I2,Q2 with no bubbles.
- Overflow, `DEPTH`=8, `DOutReady`=0:
  - Stimulus: push 10 pairs.
  - Response: 1 pair sits in the staging register and 8 in the FIFO. Pair 10 is dropped, `Overflow`=1, `Level`=8, `AlmostFull`=1. `ClrOvf` clears `Overflow`.
- Full plus simultaneous pop:
  - Stimulus: FIFO full, `PushOut` on the same edge as an accepted Q word.
  - Response: the new pair is stored, `Overflow` stays 0, `Level` stays 8.
- Reset mid-stream:
  - Stimulus: assert `Reset` while in SEND_Q with `Level`=3.
  - Response: all outputs go to their reset values and `Level`=0. A push after reset returns the new pair first.
- With `FIRC_OUT_PAIRCNT_EN` defined:
  - Stimulus: deliver 5 pairs.
  - Response: `PairCnt`=5.
  - Without the macro, `PairCnt`=0 throughout.
